// File: rtl/producer_pkg.sv
// Shared types and constants for the producer block.
// Build option: PRODUCER_LFSR_EN selects the 4-bit LFSR sequence generator.
// When it is not defined, the generator is a wrapping incrementing counter.
package producer_pkg;

    localparam int DEFAULT_DATA_W = 4;
    localparam int SEQ_W          = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [SEQ_W-1:0] LFSR_SEED = 4'b0001;
    // x^4 + x^3 + 1: feedback is the XOR of bits 3 and 2
    localparam logic [SEQ_W-1:0] LFSR_TAPS = 4'b1100;
    localparam logic [SEQ_W-1:0] CNT_SEED  = 4'h0;

`ifdef PRODUCER_LFSR_EN
    localparam logic [SEQ_W-1:0] SEQ_SEED = LFSR_SEED;
`else
    localparam logic [SEQ_W-1:0] SEQ_SEED = CNT_SEED;
`endif

    // Successor of a generator value. The LFSR never reaches 0 from a nonzero seed.
    function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] s);
`ifdef PRODUCER_LFSR_EN
        return {s[SEQ_W-2:0], ^(s & LFSR_TAPS)};
`else
        return s + SEQ_W'(1);
`endif
    endfunction

endpackage

// File: rtl/producer_if.sv
// Producer/consumer handshake bundle. The producer drives data, valid and status.
// The consumer side (or its controller) drives ready and enable.
interface producer_if
    import producer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              enable;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic [LVL_W-1:0]  level;
    logic              busy;

    modport master (
        input  enable,
        input  ready,
        output data_out,
        output valid,
        output level,
        output busy
    );

    modport slave (
        output enable,
        output ready,
        input  data_out,
        input  valid,
        input  level,
        input  busy
    );

endinterface

// File: rtl/producer_fifo.sv
// First-word-fall-through FIFO. The head entry is visible on dout whenever the FIFO is not empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module producer_fifo
    import producer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = level_q;
    // Gate the head so an empty FIFO always presents zero, including right after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are meaningless until written, so no reset is needed.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. Level tracks push minus pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/producer_unit.sv
// Producer end of the producer/consumer pair.
// Produces one generator value every INTERVAL cycles while enabled, buffers it in a FWFT FIFO,
// and offers it to the consumer over valid/ready.
// Build option: PRODUCER_LFSR_EN switches the generator from a counter to a 4-bit LFSR (see producer_pkg).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | production disabled; tick counter and generator hold
// COUNT | counting down the interval; a push is attempted when the tick reaches 0
// FULL  | last attempt found the FIFO full; retry the push every cycle
module producer_unit
    import producer_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = 4,
    parameter int INTERVAL = 3
) (
    input  logic       clock,
    input  logic       reset,
    producer_if.master bus
);
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int TICK_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(INTERVAL - 1);

    state_t            state_q;
    state_t            state_d;
    logic [TICK_W-1:0] tick_q;
    logic [SEQ_W-1:0]  seq_q;
    logic              tick_load;
    logic              tick_dec;
    logic              push;
    logic              pop;
    logic              can_push;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] fifo_dout;
    logic [LVL_W-1:0]  fifo_level;

    assign pop      = ~empty & bus.ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    assign can_push = ~full | pop;

    producer_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (DATA_W'(seq_q)),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and push decisions. Dropping enable abandons any pending item without advancing seq.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        tick_load = 1'b0;
        tick_dec  = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = COUNT;
                    tick_load = 1'b1;
                end
                COUNT: begin
                    if (tick_q != '0) begin
                        tick_dec = 1'b1;
                    end else if (can_push) begin
                        push      = 1'b1;
                        tick_load = 1'b1;
                    end else begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (can_push) begin
                        push      = 1'b1;
                        tick_load = 1'b1;
                        state_d   = COUNT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Interval down-counter; reloaded on entry to COUNT and after every successful push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else if (tick_load) begin
            tick_q <= TICK_RELOAD;
        end else if (tick_dec) begin
            tick_q <= tick_q - TICK_W'(1);
        end
    end

    // Sequence generator; advances only when its current value has actually entered the FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_q <= SEQ_SEED;
        end else if (push) begin
            seq_q <= seq_next(seq_q);
        end
    end

    assign bus.data_out = fifo_dout;
    assign bus.valid    = ~empty;
    assign bus.level    = fifo_level;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_producer_unit.sv
// Directed bench for producer_unit. One instance uses INTERVAL=3 and one uses INTERVAL=1.
// Expected data comes from a table of the generator sequence for the active build.
module tb_producer_unit;
    import producer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] lfsr_tab [15];

    always #5 clock = ~clock;

    producer_if #(.DATA_W(4), .DEPTH(4)) bus3 ();
    producer_if #(.DATA_W(4), .DEPTH(4)) bus1 ();

    producer_unit #(.DATA_W(4), .DEPTH(4), .INTERVAL(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus3.master)
    );

    producer_unit #(.DATA_W(4), .DEPTH(4), .INTERVAL(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.master)
    );

    function automatic logic [3:0] exp_item(input int k);
`ifdef PRODUCER_LFSR_EN
        return lfsr_tab[k % 15];
`else
        return 4'(k % 16);
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus3.enable = 1'b0;
        bus3.ready  = 1'b0;
        bus1.enable = 1'b0;
        bus1.ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Consume n items from bus3 with ready held high, comparing against the sequence from index start.
    task automatic collect(input int n, input int start, input string name);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 300) begin
            if (bus3.valid === 1'b1) begin
                n_tests++;
                if (bus3.data_out !== exp_item(start + got)) begin
                    n_fail++;
                    $display("FAIL %s item %0d: got %0d expected %0d", name, got, bus3.data_out, exp_item(start + got));
                end
                got++;
            end
            step();
            cyc++;
        end
        n_tests++;
        if (got !== n) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d items expected %0d", name, got, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus3.enable = 1'b0;
        bus3.ready  = 1'b0;
        bus1.enable = 1'b0;
        bus1.ready  = 1'b0;
        #2;
        n_tests++;
        if (bus3.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus3.valid); end
        n_tests++;
        if (bus3.level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus3.level); end
        n_tests++;
        if (bus3.data_out !== 4'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", bus3.data_out); end
        n_tests++;
        if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus3.busy); end
        n_tests++;
        if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
        do_reset();
    endtask

    task automatic test_rate();
        int n;
        int exp_n;
        logic [2:0] max_lvl = '0;
        do_reset();
        bus3.ready  = 1'b1;
        bus3.enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin
                step();
                n++;
                if (bus3.level > max_lvl) max_lvl = bus3.level;
            end while (bus3.valid !== 1'b1 && n < 10);
            exp_n = (i == 0) ? 4 : 3;
            n_tests++;
            if (n !== exp_n) begin n_fail++; $display("FAIL rate_gap %0d: got %0d edges expected %0d", i, n, exp_n); end
            n_tests++;
            if (bus3.data_out !== exp_item(i)) begin
                n_fail++;
                $display("FAIL rate_data %0d: got %0d expected %0d", i, bus3.data_out, exp_item(i));
            end
        end
        n_tests++;
        if (max_lvl !== 3'd1) begin n_fail++; $display("FAIL rate_maxlevel: got %0d expected 1", max_lvl); end
    endtask

    task automatic test_backpressure();
        logic hold_ok = 1'b1;
        do_reset();
        bus3.ready  = 1'b0;
        bus3.enable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i >= 4 && (bus3.valid !== 1'b1 || bus3.data_out !== exp_item(0))) hold_ok = 1'b0;
        end
        n_tests++;
        if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %0b expected 1", hold_ok); end
        n_tests++;
        if (bus3.level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d expected 4", bus3.level); end
        n_tests++;
        if (bus3.busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %0b expected 1", bus3.busy); end
        n_tests++;
        if (dut.state_q !== FULL) begin n_fail++; $display("FAIL bp_state: got %0d expected %0d", dut.state_q, FULL); end
        n_tests++;
        if (bus3.data_out !== exp_item(0)) begin
            n_fail++;
            $display("FAIL bp_head: got %0d expected %0d", bus3.data_out, exp_item(0));
        end
        bus3.ready = 1'b1;
        collect(6, 0, "bp_drain");
    endtask

    task automatic test_wrap();
        do_reset();
        bus3.ready  = 1'b1;
        bus3.enable = 1'b1;
        collect(20, 0, "wrap");
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus1.ready  = 1'b0;
        bus1.enable = 1'b1;
        repeat (6) step();
        n_tests++;
        if (bus1.level !== 3'd4) begin n_fail++; $display("FAIL b2b_fill: got %0d expected 4", bus1.level); end
        bus1.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (bus1.data_out !== exp_item(i)) begin
                n_fail++;
                $display("FAIL b2b_data %0d: got %0d expected %0d", i, bus1.data_out, exp_item(i));
            end
            step();
            n_tests++;
            if (bus1.level !== 3'd4) begin n_fail++; $display("FAIL b2b_level %0d: got %0d expected 4", i, bus1.level); end
        end
        bus1.enable = 1'b0;
        bus1.ready  = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus3.ready  = 1'b0;
        bus3.enable = 1'b1;
        repeat (10) step();
        n_tests++;
        if (bus3.level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level: got %0d expected 3", bus3.level); end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus3.valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b expected 0", bus3.valid); end
        n_tests++;
        if (bus3.level !== 3'd0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", bus3.level); end
        n_tests++;
        if (bus3.data_out !== 4'd0) begin n_fail++; $display("FAIL mid_data: got %0d expected 0", bus3.data_out); end
        bus3.enable = 1'b0;
        step();
        reset = 1'b0;
        step();
        bus3.ready  = 1'b1;
        bus3.enable = 1'b1;
        collect(1, 0, "mid_first");
    endtask

    task automatic test_enable_drop();
        do_reset();
        bus3.ready  = 1'b0;
        bus3.enable = 1'b1;
        repeat (10) step();
        n_tests++;
        if (bus3.level !== 3'd3) begin n_fail++; $display("FAIL drop_pre_level: got %0d expected 3", bus3.level); end
        bus3.enable = 1'b0;
        bus3.ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus3.data_out !== exp_item(i)) begin
                n_fail++;
                $display("FAIL drop_data %0d: got %0d expected %0d", i, bus3.data_out, exp_item(i));
            end
            step();
            n_tests++;
            if (bus3.level !== 3'(2 - i)) begin n_fail++; $display("FAIL drop_level %0d: got %0d expected %0d", i, bus3.level, 2 - i); end
            n_tests++;
            if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy %0d: got %0b expected 0", i, bus3.busy); end
        end
        repeat (4) step();
        n_tests++;
        if (bus3.level !== 3'd0) begin n_fail++; $display("FAIL drop_idle_level: got %0d expected 0", bus3.level); end
        n_tests++;
        if (bus3.valid !== 1'b0) begin n_fail++; $display("FAIL drop_idle_valid: got %0b expected 0", bus3.valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        lfsr_tab = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                     4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
        test_reset();
        test_rate();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_midop();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
